// File: rtl/sysid_probe_pkg.sv
// =============================================================================
//  Module   : sysid_probe_pkg
//  Brief    : Shared types and constants for the system-ID probe master.
//  Revision : 1.0
// =============================================================================
`default_nettype none

package sysid_probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_RD_TS  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } probe_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int unsigned SYSID_ADDR_ID = 0;
  localparam int unsigned SYSID_ADDR_TS = 1;

endpackage

`default_nettype wire

// File: rtl/sysid_probe_master_if.sv
// =============================================================================
//  Module   : sysid_probe_master_if
//  Brief    : Avalon-MM read-only bus between the probe master and sysid slave.
//  Revision : 1.0
// =============================================================================
`default_nettype none

interface sysid_probe_master_if #(
  parameter int ADDR_W = 1
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

`default_nettype wire

// File: rtl/avm_read_timer.sv
// =============================================================================
//  Module   : avm_read_timer
//  Brief    : Counts stalled bus cycles; flags the cycle the limit is reached.
//  Revision : 1.0
// =============================================================================
`default_nettype none

module avm_read_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clear,
  input  wire logic i_count_en,
  output logic      o_expired
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= 16'd0;
    end else if (i_count_en) begin
      r_count <= r_count + 16'd1;
    end
  end

  // Fires on the stalled cycle whose increment would bring the count to the limit.
  assign o_expired = i_count_en && (r_count == 16'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/sysid_probe_master.sv
// =============================================================================
//  Module   : sysid_probe_master
//  Brief    : Reads sysid ID and timestamp words, compares to expected image.
//  Revision : 1.0
// =============================================================================
`default_nettype none

module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter int          ADDR_W      = 1,
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1542719444,
  parameter int          TIMEOUT_CYC = 16,
  parameter int          MAX_RETRIES = 2
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            start,
  sysid_probe_master_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           err_code,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);

  probe_state_e      r_state;
  logic              r_read;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [1:0]        r_err;
  logic [31:0]       r_id;
  logic [31:0]       r_ts;
  logic [3:0]        r_retry;

  logic w_in_rd;
  logic w_xfer;
  logic w_count_en;
  logic w_timer_clr;
  logic w_expire;

  assign w_in_rd     = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign w_xfer      = w_in_rd && r_read && !avm.avm_waitrequest;
  assign w_count_en  = w_in_rd && r_read && avm.avm_waitrequest;
  assign w_timer_clr = !w_count_en;

  avm_read_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk        (clock),
    .rst        (reset),
    .i_clear    (w_timer_clr),
    .i_count_en (w_count_en),
    .o_expired  (w_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_read  <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= ERR_NONE;
      r_id    <= 32'd0;
      r_ts    <= 32'd0;
      r_retry <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pass  <= 1'b0;
            r_err   <= ERR_NONE;
            r_retry <= 4'd0;
            r_busy  <= 1'b1;
            r_read  <= 1'b1;
            r_addr  <= ADDR_W'(SYSID_ADDR_ID);
            r_state <= ST_RD_ID;
          end
        end
        ST_RD_ID, ST_RD_TS: begin
          // A dropped read here is the one-cycle gap after an abort; re-arm it.
          if (!r_read) begin
            r_read <= 1'b1;
          end else if (w_expire) begin
            r_read <= 1'b0;
            r_addr <= ADDR_W'(SYSID_ADDR_ID);
            if (r_retry < 4'(MAX_RETRIES)) begin
              r_retry <= r_retry + 4'd1;
              r_state <= ST_RD_ID;
            end else begin
              r_err   <= ERR_TIMEOUT;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end
          end else if (w_xfer) begin
            if (r_state == ST_RD_ID) begin
              r_id    <= avm.avm_readdata;
              r_addr  <= ADDR_W'(SYSID_ADDR_TS);
              r_state <= ST_RD_TS;
            end else begin
              r_ts    <= avm.avm_readdata;
              r_read  <= 1'b0;
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (r_id != EXPECTED_ID) begin
            r_err <= ERR_ID;
          end else if (r_ts != EXPECTED_TS) begin
            r_err <= ERR_TS;
          end else begin
            r_pass <= 1'b1;
          end
          r_done  <= 1'b1;
          r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_read  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm.avm_address = r_addr;
  assign avm.avm_read    = r_read;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_code        = r_err;
  assign id_value        = r_id;
  assign ts_value        = r_ts;

endmodule

`default_nettype wire

// File: tb/tb_sysid_probe_master.sv
// =============================================================================
//  Module   : tb_sysid_probe_master
//  Brief    : Self-checking bench for the sysid probe master with a stallable slave.
//  Revision : 1.0
// =============================================================================
`default_nettype none

module tb_sysid_probe_master;
  import sysid_probe_pkg::*;

  localparam int          T   = 16;
  localparam int          R   = 2;
  localparam int          BIG = 1000000;
  localparam logic [31:0] EID = 32'd0;
  localparam logic [31:0] ETS = 32'd1542719444;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  sysid_probe_master_if #(.ADDR_W(1)) avm ();

  sysid_probe_master #(
    .ADDR_W      (1),
    .EXPECTED_ID (EID),
    .EXPECTED_TS (ETS),
    .TIMEOUT_CYC (T),
    .MAX_RETRIES (R)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (avm.master),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_code (err_code),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Slave configuration, written by the stimulus only.
  logic [31:0] mem0 = 32'd0;
  logic [31:0] mem1 = 32'd0;
  int          stall0 = 0;
  int          stall1 = 0;
  int          stuck_until = 0;

  // Slave bookkeeping, written by the slave only.
  int   s_att  = 0;
  int   s_cnt  = 0;
  int   s_lim  = 0;
  bit   s_seen = 1'b0;
  logic s_addr = 1'b0;

  // Each fresh access stalls for its configured count; early ID attempts can be stuck.
  always @(negedge clock) begin
    if (avm.avm_read !== 1'b1) begin
      s_seen = 1'b0;
      avm.avm_waitrequest = 1'b0;
    end else begin
      if (!s_seen || avm.avm_address != s_addr) begin
        s_seen = 1'b1;
        s_cnt  = 0;
        s_addr = avm.avm_address;
        if (s_addr == 1'b0) s_att++;
      end
      s_lim = s_addr ? stall1 : ((s_att <= stuck_until) ? BIG : stall0);
      avm.avm_waitrequest = (s_cnt < s_lim);
      s_cnt++;
    end
    avm.avm_readdata = (avm.avm_read === 1'b1 && !avm.avm_waitrequest)
                       ? (s_addr ? mem1 : mem0) : $urandom();
  end

  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic run_probe(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input int sid, input int sts, input int stuck, input bit poke);
    int         lat = 0;
    int         att = 0;
    int         done_exp;
    int         done_k = -1;
    int         ndone = 0;
    int         n_att = 0;
    int         busy_bad = 0;
    int         stab_bad = 0;
    int         run = 0;
    bit         ok = 1'b0;
    logic [1:0] e_exp;
    logic       prev_read = 1'b0;
    logic       prev_addr = 1'b0;
    logic       prev_wr = 1'b0;

    // Each attempt: an aborted read costs T stalled cycles plus one idle cycle.
    for (int a = 0; a <= R; a++) begin
      int lid;
      att++;
      lid = (a < stuck) ? BIG : sid;
      if (lid >= T) begin
        lat += T + 1;
        continue;
      end
      lat += lid + 1;
      m_id = d0;
      if (sts >= T) begin
        lat += T + 1;
        continue;
      end
      lat += sts + 1;
      m_ts = d1;
      ok = 1'b1;
      break;
    end
    done_exp = ok ? lat + 2 : lat;
    if (!ok)             e_exp = ERR_TIMEOUT;
    else if (d0 != EID)  e_exp = ERR_ID;
    else if (d1 != ETS)  e_exp = ERR_TS;
    else                 e_exp = ERR_NONE;

    mem0 = d0;
    mem1 = d1;
    stall0 = sid;
    stall1 = sts;
    stuck_until = s_att + stuck;
    start = 1'b1;
    for (int k = 1; k <= done_exp + 2; k++) begin
      @(negedge clock); #1;
      start = poke && (k == 2 || k == done_exp);
      if (done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (busy !== (k <= done_exp)) busy_bad++;
      if (avm.avm_read === 1'b1 && !prev_read && avm.avm_address == 1'b0) n_att++;
      if (prev_read && prev_wr && run < T &&
          (avm.avm_read !== 1'b1 || avm.avm_address !== prev_addr)) stab_bad++;
      run = (avm.avm_read === 1'b1 && avm.avm_waitrequest) ? run + 1 : 0;
      prev_read = avm.avm_read;
      prev_addr = avm.avm_address;
      prev_wr   = avm.avm_waitrequest;
    end
    start = 1'b0;

    chk({tag, ".done_cycle"}, done_k, done_exp);
    chk({tag, ".done_count"}, ndone, 1);
    chk({tag, ".busy"}, busy_bad, 0);
    chk({tag, ".bus_stable"}, stab_bad, 0);
    chk({tag, ".attempts"}, n_att, att);
    chk({tag, ".pass"}, {31'd0, pass}, {31'd0, (e_exp == ERR_NONE)});
    chk({tag, ".err_code"}, {30'd0, err_code}, {30'd0, e_exp});
    chk({tag, ".id_value"}, id_value, m_id);
    chk({tag, ".ts_value"}, ts_value, m_ts);
    chk({tag, ".read_idle"}, {31'd0, avm.avm_read}, 32'd0);
  endtask

  initial begin
    int   quiet;
    int   sid;
    int   sts;
    logic [31:0] d0;
    logic [31:0] d1;

    repeat (3) @(negedge clock);
    #1;
    chk("reset.busy",     {31'd0, busy},          32'd0);
    chk("reset.done",     {31'd0, done},          32'd0);
    chk("reset.pass",     {31'd0, pass},          32'd0);
    chk("reset.err_code", {30'd0, err_code},      32'd0);
    chk("reset.id_value", id_value,               32'd0);
    chk("reset.ts_value", ts_value,               32'd0);
    chk("reset.read",     {31'd0, avm.avm_read},  32'd0);
    chk("reset.address",  {31'd0, avm.avm_address}, 32'd0);
    reset = 1'b0;
    @(negedge clock); #1;

    run_probe("zero_wait", EID, ETS, 0, 0, 0, 1'b0);
    run_probe("bad_id", 32'h7, ETS, 0, 0, 0, 1'b0);
    run_probe("bad_ts", EID, 32'd1542719445, 0, 0, 0, 1'b0);
    run_probe("stall3", EID, ETS, 3, 3, 0, 1'b0);
    run_probe("stuck", EID, ETS, BIG, BIG, 0, 1'b1);
    run_probe("edge_ok", EID, ETS, T - 1, T - 1, 0, 1'b0);
    run_probe("ts_timeout", 32'h1234, ETS, 1, T, 0, 1'b0);
    run_probe("retry_ok", EID, ETS, 2, 1, 1, 1'b1);

    // Reset while the timestamp read is stalled.
    mem0 = 32'h55;
    mem1 = ETS;
    stall0 = 0;
    stall1 = BIG;
    stuck_until = s_att;
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    chk("rst_mid.read_pre", {31'd0, avm.avm_read},    32'd1);
    chk("rst_mid.addr_pre", {31'd0, avm.avm_address}, 32'd1);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("rst_mid.read",     {31'd0, avm.avm_read}, 32'd0);
    chk("rst_mid.busy",     {31'd0, busy},         32'd0);
    chk("rst_mid.id_value", id_value,              32'd0);
    chk("rst_mid.ts_value", ts_value,              32'd0);
    chk("rst_mid.err_code", {30'd0, err_code},     32'd0);
    reset = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) quiet++;
    end
    chk("rst_mid.no_result", quiet, 0);
    m_id = 32'd0;
    m_ts = 32'd0;
    run_probe("after_reset", EID, ETS, 0, 0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      d0  = ($urandom_range(0, 2) != 0) ? EID : $urandom();
      d1  = ($urandom_range(0, 2) != 0) ? ETS : $urandom();
      sid = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 1, T + 1)) : int'($urandom_range(0, 4));
      sts = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 1, T + 1)) : int'($urandom_range(0, 4));
      run_probe($sformatf("rand%0d", i), d0, d1, sid, sts,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
